dma_cmd_queue: RTL and testbench

- CPU-facing MMIO front end for dma_ctrl; sits directly upstream of it.
- Captures DRAM→SRAM descriptors (src, dst, width) written by the core and buffers them in a small FIFO.
- Launches each descriptor into dma_ctrl with a one-cycle cmd pulse, then tracks dma_ctrl's stall until that transfer completes.
- Exposes status, a completion counter and a level interrupt.

---
 rtl/dma_cmd_queue_if.sv | 25 ++
 rtl/dma_cmd_queue.sv | 174 +++++++++++++++++
 tb/tb_dma_cmd_queue.sv | 302 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/dma_cmd_queue_if.sv
// MMIO + dma_ctrl bundle for dma_cmd_queue; slave = the queue, master = CPU/dma_ctrl side.
// Pure wiring: no latency and no flow control of its own.
interface dma_cmd_queue_if;
  logic [4:0]  cpuAddress;
  logic [31:0] cpuWriteData;
  logic        cpuWriteEnable;
  logic        cpuReadEnable;
  logic [31:0] cpuReadData;
  logic [1:0]  cmd;
  logic [31:0] srcAddress;
  logic [31:0] dstAddress;
  logic [9:0]  width;
  logic        dmaStall;
  logic        irq;

  modport slave (
    input  cpuAddress, cpuWriteData, cpuWriteEnable, cpuReadEnable, dmaStall,
    output cpuReadData, cmd, srcAddress, dstAddress, width, irq
  );

  modport master (
    output cpuAddress, cpuWriteData, cpuWriteEnable, cpuReadEnable, dmaStall,
    input  cpuReadData, cmd, srcAddress, dstAddress, width, irq
  );
endinterface

// File: rtl/dma_cmd_queue.sv
// MMIO descriptor FIFO feeding dma_ctrl; cmd pulses one cycle after a pop, reads return next cycle.
// Backpressure: issue waits for !dmaStall and completion; pushes to a full queue drop and flag overflow.
module dma_cmd_queue #(
  parameter int DEPTH = 4
) (
  input  logic            clk,
  input  logic            reset,
  dma_cmd_queue_if.slave  bus
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT_START, S_WAIT_DONE} state_t;

  state_t        r_state;
  logic [31:0]   r_src_stg, r_dst_stg;
  logic [9:0]    r_wid_stg;
  logic [31:0]   r_mem_src [DEPTH];
  logic [31:0]   r_mem_dst [DEPTH];
  logic [9:0]    r_mem_wid [DEPTH];
  logic [AW-1:0] r_wr_ptr, r_rd_ptr;
  logic [CW-1:0] r_count;
  logic          r_overflow, r_width_err, r_irq_en, r_irq;
  logic [15:0]   r_done_cnt;
  logic [1:0]    r_cmd;
  logic [31:0]   r_src_out, r_dst_out, r_rdata;
  logic [9:0]    r_wid_out;

  logic [2:0]    w_sel;
  logic          w_empty, w_full, w_push_req, w_push, w_pop, w_done, w_irqctl_wr;
  logic [31:0]   w_count32, w_status, w_rdata;

  assign w_sel       = bus.cpuAddress[4:2];
  assign w_empty     = (r_count == '0);
  assign w_full      = (r_count == CW'(DEPTH));
  assign w_push_req  = bus.cpuWriteEnable && (w_sel == 3'd3) && bus.cpuWriteData[0];
  assign w_push      = w_push_req && !w_full && (r_wid_stg != 10'd0);
  assign w_pop       = (r_state == S_IDLE) && !w_empty && !bus.dmaStall;
  assign w_done      = (r_state == S_WAIT_DONE) && !bus.dmaStall;
  assign w_irqctl_wr = bus.cpuWriteEnable && (w_sel == 3'd5);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_src_stg <= '0;
      r_dst_stg <= '0;
      r_wid_stg <= '0;
    end else if (bus.cpuWriteEnable) begin
      case (w_sel)
        3'd0:    r_src_stg <= bus.cpuWriteData;
        3'd1:    r_dst_stg <= bus.cpuWriteData;
        3'd2:    r_wid_stg <= bus.cpuWriteData[9:0];
        default: ;
      endcase
    end
  end

  // Storage needs no reset: only entries covered by r_count are ever read.
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem_src[r_wr_ptr] <= r_src_stg;
      r_mem_dst[r_wr_ptr] <= r_dst_stg;
      r_mem_wid[r_wr_ptr] <= r_wid_stg;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + AW'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + AW'(1);
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: ;
      endcase
    end
  end

  // Sticky flags; a set event beats a clear written in the same cycle.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_overflow  <= 1'b0;
      r_width_err <= 1'b0;
      r_irq_en    <= 1'b0;
      r_irq       <= 1'b0;
    end else begin
      if (w_irqctl_wr) r_irq_en <= bus.cpuWriteData[0];

      if (w_push_req && w_full)                            r_overflow <= 1'b1;
      else if (w_irqctl_wr && bus.cpuWriteData[1])         r_overflow <= 1'b0;

      if (w_push_req && !w_full && (r_wid_stg == 10'd0))   r_width_err <= 1'b1;
      else if (w_irqctl_wr && bus.cpuWriteData[1])         r_width_err <= 1'b0;

      if (w_done && r_irq_en)                              r_irq <= 1'b1;
      else if (w_irqctl_wr && bus.cpuWriteData[1])         r_irq <= 1'b0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state    <= S_IDLE;
      r_cmd      <= 2'b00;
      r_src_out  <= '0;
      r_dst_out  <= '0;
      r_wid_out  <= '0;
      r_done_cnt <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          r_cmd <= 2'b00;
          if (w_pop) begin
            r_src_out <= r_mem_src[r_rd_ptr];
            r_dst_out <= r_mem_dst[r_rd_ptr];
            r_wid_out <= r_mem_wid[r_rd_ptr];
            r_cmd     <= 2'b01;
            r_state   <= S_ISSUE;
          end
        end
        S_ISSUE: begin
          r_cmd   <= 2'b00;
          r_state <= S_WAIT_START;
        end
        S_WAIT_START: begin
          r_cmd <= 2'b00;
          if (bus.dmaStall) r_state <= S_WAIT_DONE;
        end
        S_WAIT_DONE: begin
          r_cmd <= 2'b00;
          if (w_done) begin
            r_done_cnt <= r_done_cnt + 16'd1;
            r_state    <= S_IDLE;
          end
        end
        default: begin
          r_cmd   <= 2'b00;
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign w_count32 = 32'(r_count);
  assign w_status  = {23'd0, r_width_err, r_overflow, (r_state != S_IDLE),
                      w_full, w_empty, w_count32[3:0]};

  always_comb begin
    w_rdata = '0;
    case (w_sel)
      3'd0:    w_rdata = r_src_stg;
      3'd1:    w_rdata = r_dst_stg;
      3'd2:    w_rdata = {22'd0, r_wid_stg};
      3'd4:    w_rdata = w_status;
      3'd5:    w_rdata = {31'd0, r_irq_en};
      3'd6:    w_rdata = {16'd0, r_done_cnt};
      default: w_rdata = '0;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_rdata <= '0;
    else       r_rdata <= bus.cpuReadEnable ? w_rdata : 32'd0;
  end

  assign bus.cpuReadData = r_rdata;
  assign bus.cmd         = r_cmd;
  assign bus.srcAddress  = r_src_out;
  assign bus.dstAddress  = r_dst_out;
  assign bus.width       = r_wid_out;
  assign bus.irq         = r_irq;
endmodule

// File: tb/tb_dma_cmd_queue.sv
// Bench for dma_cmd_queue: directed MMIO sequences plus randomized descriptor bursts,
// checked against a queue-based model and a simple dma_ctrl stall responder.
module tb_dma_cmd_queue;
  localparam int DEPTH = 4;

  typedef struct {
    logic [31:0] src;
    logic [31:0] dst;
    logic [9:0]  wid;
  } desc_t;

  logic clk = 1'b0;
  logic reset = 1'b1;
  dma_cmd_queue_if bus ();

  dma_cmd_queue #(.DEPTH(DEPTH)) dut (.clk(clk), .reset(reset), .bus(bus.slave));

  always #5 clk = ~clk;

  int    n_checks = 0;
  int    n_fail   = 0;
  desc_t exp_q[$];
  bit    model_ovf = 0, model_werr = 0;
  int    model_done = 0;
  int    n_issued = 0;
  int    stall_len = 8;
  logic  hold_stall = 1'b0;
  logic  m_stall = 1'b0;
  int    m_cnt = 0;
  bit    saw_cmd = 0;
  logic [1:0] prev_cmd = 2'b00;

  assign bus.dmaStall = m_stall | hold_stall;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  // dma_ctrl stand-in: goes busy the cycle after it sees cmd, stays busy stall_len cycles.
  always begin
    @(posedge clk);
    #1;
    if (reset) begin
      m_stall = 1'b0; m_cnt = 0; saw_cmd = 0;
    end else begin
      if (m_cnt > 0) begin
        m_cnt--;
        if (m_cnt == 0) m_stall = 1'b0;
      end
      if (saw_cmd) begin
        m_stall = 1'b1; m_cnt = stall_len; saw_cmd = 0;
      end
    end
  end

  always @(negedge clk) begin
    if (!reset) begin
      if (bus.cmd !== 2'b00) begin
        desc_t d;
        check("cmd_code", {30'd0, bus.cmd}, 32'd1);
        check("cmd_during_stall", {31'd0, bus.dmaStall}, 32'd0);
        check("cmd_single_cycle", {30'd0, prev_cmd}, 32'd0);
        check("cmd_expected", 32'(exp_q.size() != 0), 32'd1);
        if (exp_q.size() != 0) begin
          d = exp_q.pop_front();
          check("issue_src", bus.srcAddress, d.src);
          check("issue_dst", bus.dstAddress, d.dst);
          check("issue_width", {22'd0, bus.width}, {22'd0, d.wid});
        end
        saw_cmd = 1;
        n_issued++;
      end
      prev_cmd = bus.cmd;
    end else begin
      prev_cmd = 2'b00;
    end
  end

  task automatic cpu_write(input logic [4:0] a, input logic [31:0] d);
    @(negedge clk);
    bus.cpuAddress = a; bus.cpuWriteData = d; bus.cpuWriteEnable = 1'b1;
    @(negedge clk);
    bus.cpuWriteEnable = 1'b0;
  endtask

  task automatic cpu_read(input logic [4:0] a, output logic [31:0] d);
    @(negedge clk);
    bus.cpuAddress = a; bus.cpuReadEnable = 1'b1;
    @(negedge clk);
    bus.cpuReadEnable = 1'b0;
    d = bus.cpuReadData;
  endtask

  task automatic model_push(input logic [31:0] s, input logic [31:0] d, input logic [9:0] w);
    desc_t e;
    if (exp_q.size() >= DEPTH) model_ovf = 1;
    else if (w == 10'd0) model_werr = 1;
    else begin
      e.src = s; e.dst = d; e.wid = w;
      exp_q.push_back(e);
      model_done++;
    end
  endtask

  task automatic push(input logic [31:0] s, input logic [31:0] d, input logic [9:0] w);
    cpu_write(5'h00, s);
    cpu_write(5'h04, d);
    cpu_write(5'h08, {22'd0, w});
    cpu_write(5'h0C, 32'd1);
    model_push(s, d, w);
  endtask

  function automatic logic [31:0] exp_status(input int cnt, input bit busy);
    logic [3:0] c4;
    c4 = 4'(cnt);
    return {23'd0, model_werr, model_ovf, busy, (cnt == DEPTH), (cnt == 0), c4};
  endfunction

  task automatic wait_idle(input string tag);
    logic [31:0] r;
    r = '0;
    for (int i = 0; i < 3000; i++) begin
      cpu_read(5'h10, r);
      if (r[6] == 1'b0 && r[4] == 1'b1) break;
    end
    check(tag, {30'd0, r[6], r[4]}, 32'd1);
  endtask

  task automatic wait_irq(input string tag);
    for (int i = 0; i < 500; i++) begin
      @(negedge clk);
      if (bus.irq === 1'b1) break;
    end
    check(tag, {31'd0, bus.irq}, 32'd1);
  endtask

  task automatic clear_flags();
    cpu_write(5'h14, 32'h2);
    model_ovf = 0; model_werr = 0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog expired: observed=running required=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] r;
    int base, n, issued0;
    logic [31:0] s, d;
    logic [9:0] w;

    bus.cpuAddress = '0; bus.cpuWriteData = '0;
    bus.cpuWriteEnable = 1'b0; bus.cpuReadEnable = 1'b0;

    // Reset state
    repeat (2) @(negedge clk);
    check("rst_cmd", {30'd0, bus.cmd}, 32'd0);
    check("rst_irq", {31'd0, bus.irq}, 32'd0);
    check("rst_src", bus.srcAddress, 32'd0);
    check("rst_dst", bus.dstAddress, 32'd0);
    check("rst_width", {22'd0, bus.width}, 32'd0);
    check("rst_rdata", bus.cpuReadData, 32'd0);
    reset = 1'b0;
    cpu_read(5'h10, r); check("rst_status", r, exp_status(0, 0));
    cpu_read(5'h18, r); check("rst_donecnt", r, 32'd0);
    cpu_read(5'h14, r); check("rst_irqctl", r, 32'd0);
    cpu_read(5'h00, r); check("rst_src_stg", r, 32'd0);

    // Single transfer
    stall_len = 8;
    push(32'h0000_1000, 32'h0000_0040, 10'd3);
    wait_idle("single_drain");
    cpu_read(5'h18, r); check("single_donecnt", r, 32'd1);
    cpu_read(5'h10, r); check("single_status", r, exp_status(0, 0));
    cpu_read(5'h08, r); check("width_readback", r, 32'd3);
    cpu_write(5'h08, 32'hFFFF_FC07);
    cpu_read(5'h08, r); check("width_upper_zero", r, 32'h0000_0007);
    cpu_read(5'h0C, r); check("push_reads_zero", r, 32'd0);
    cpu_read(5'h1C, r); check("unmapped_read", r, 32'd0);

    // Overflow with stall held
    hold_stall = 1'b1;
    for (int i = 0; i < 5; i++) push(32'h2000 + 32'(i * 16), 32'h100 + 32'(i), 10'(i + 1));
    cpu_read(5'h10, r); check("ovf_status", r, 32'h0000_00A4);
    check("ovf_model_status", r, exp_status(exp_q.size(), 0));
    hold_stall = 1'b0;
    wait_idle("ovf_drain");
    cpu_read(5'h18, r); check("ovf_donecnt", r, 32'd5);
    clear_flags();
    cpu_read(5'h10, r); check("ovf_cleared", r, exp_status(0, 0));

    // Zero width rejected
    issued0 = n_issued;
    push(32'h3000, 32'h3000, 10'd0);
    repeat (10) @(negedge clk);
    cpu_read(5'h10, r); check("werr_status", r, 32'h0000_0110);
    check("werr_no_issue", 32'(n_issued), 32'(issued0));
    clear_flags();
    cpu_read(5'h10, r); check("werr_cleared", r, 32'h0000_0010);

    // Interrupt behaviour
    stall_len = 20;
    cpu_write(5'h14, 32'h1);
    cpu_read(5'h14, r); check("irqen_readback", r, 32'd1);
    base = model_done;
    hold_stall = 1'b1;
    push(32'h4000, 32'h4400, 10'd16);
    push(32'h5000, 32'h5500, 10'd17);
    @(negedge clk); hold_stall = 1'b0;
    wait_irq("irq_first");
    cpu_read(5'h18, r); check("irq_first_donecnt", r, 32'(base + 1));
    check("irq_held", {31'd0, bus.irq}, 32'd1);
    cpu_write(5'h14, 32'h3);
    check("irq_cleared", {31'd0, bus.irq}, 32'd0);
    wait_irq("irq_second");
    cpu_read(5'h18, r); check("irq_second_donecnt", r, 32'(base + 2));
    cpu_write(5'h14, 32'h2);
    check("irq_off", {31'd0, bus.irq}, 32'd0);
    wait_idle("irq_drain");

    // Push on the pop cycle
    stall_len = 6;
    hold_stall = 1'b1;
    push(32'h6000, 32'h6600, 10'd5);
    cpu_write(5'h00, 32'h7000);
    cpu_write(5'h04, 32'h7700);
    cpu_write(5'h08, 32'd9);
    @(negedge clk);
    bus.cpuAddress = 5'h0C; bus.cpuWriteData = 32'd1; bus.cpuWriteEnable = 1'b1;
    hold_stall = 1'b0;
    @(negedge clk);
    bus.cpuWriteEnable = 1'b0;
    model_push(32'h7000, 32'h7700, 10'd9);
    cpu_read(5'h10, r); check("pushpop_status", r, 32'h0000_0041);
    wait_idle("pushpop_drain");
    cpu_read(5'h18, r); check("pushpop_donecnt", r, 32'(model_done));

    // Randomized bursts
    for (int rnd = 0; rnd < 6; rnd++) begin
      stall_len = $urandom_range(1, 6);
      hold_stall = 1'b1;
      n = $urandom_range(1, 6);
      for (int k = 0; k < n; k++) begin
        s = $urandom; d = $urandom;
        w = ($urandom_range(0, 4) == 0) ? 10'd0 : 10'($urandom_range(1, 1023));
        push(s, d, w);
      end
      cpu_read(5'h10, r); check("rnd_status_held", r, exp_status(exp_q.size(), 0));
      hold_stall = 1'b0;
      wait_idle("rnd_drain");
      check("rnd_model_empty", 32'(exp_q.size()), 32'd0);
      cpu_read(5'h18, r); check("rnd_donecnt", r, 32'(model_done) & 32'hFFFF);
      cpu_read(5'h10, r); check("rnd_status_done", r, exp_status(0, 0));
      clear_flags();
    end

    // Reset during WAIT_DONE with two queued
    stall_len = 2;
    cpu_write(5'h14, 32'h1);
    push(32'h8000, 32'h8800, 10'd4);
    wait_idle("pre_reset_drain");
    check("pre_reset_irq", {31'd0, bus.irq}, 32'd1);
    stall_len = 40;
    hold_stall = 1'b1;
    push(32'h9000, 32'h9900, 10'd1);
    push(32'hA000, 32'hAA00, 10'd2);
    push(32'hB000, 32'hBB00, 10'd3);
    issued0 = n_issued;
    @(negedge clk); hold_stall = 1'b0;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (n_issued != issued0) break;
    end
    check("pre_reset_issue", 32'(n_issued), 32'(issued0 + 1));
    repeat (5) @(negedge clk);
    #2 reset = 1'b1;
    #1;
    check("arst_cmd", {30'd0, bus.cmd}, 32'd0);
    check("arst_irq", {31'd0, bus.irq}, 32'd0);
    check("arst_src", bus.srcAddress, 32'd0);
    check("arst_width", {22'd0, bus.width}, 32'd0);
    exp_q.delete();
    model_ovf = 0; model_werr = 0; model_done = 0;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    cpu_read(5'h10, r); check("arst_status", r, exp_status(0, 0));
    cpu_read(5'h18, r); check("arst_donecnt", r, 32'd0);
    cpu_read(5'h14, r); check("arst_irqctl", r, 32'd0);
    cpu_read(5'h00, r); check("arst_src_stg", r, 32'd0);
    repeat (60) @(negedge clk);
    check("arst_no_issue", 32'(n_issued), 32'(issued0 + 1));

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end
endmodule
